// File: rtl/cell_alloc_ctrl.sv
// Ingress buffer allocation: pops a free address per cell, writes the cell, queues {addr, deadline} for the scheduler.
// Latency: cell accept N -> buffer write N+1 -> descriptor valid N+2 (earliest); one cell per cycle sustained.
// Backpressure: cell_ready drops on an empty pool or a full 2-entry descriptor queue; releases stall while the free FIFO is full.
module cell_alloc_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DL_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cell_valid,
    output logic                  cell_ready,
    input  logic [DATA_WIDTH-1:0] cell_data,
    input  logic [DL_WIDTH-1:0]   cell_deadline,
    output logic                  fl_rd_en,
    input  logic [ADDR_WIDTH-1:0] fl_rd_data,
    input  logic                  fl_empty,
    output logic                  fl_wr_en,
    output logic [ADDR_WIDTH-1:0] fl_wr_data,
    input  logic                  fl_full,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [ADDR_WIDTH-1:0] desc_addr,
    output logic [DL_WIDTH-1:0]   desc_deadline,
    input  logic                  rel_valid,
    output logic                  rel_ready,
    input  logic [ADDR_WIDTH-1:0] rel_addr,
    output logic [ADDR_WIDTH:0]   in_use_cnt,
    output logic                  err_double_free
);
    localparam int POOL = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] POOL_CELLS = (ADDR_WIDTH+1)'(POOL);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DL_WIDTH-1:0]   dl;
    } desc_t;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [DL_WIDTH-1:0]   s1_dl_q, s1_dl_d;
    desc_t                 head_q, head_d, tail_q, tail_d;
    logic [1:0]            desc_cnt_q, desc_cnt_d;
    logic [POOL-1:0]       bitmap_q, bitmap_d;
    logic [ADDR_WIDTH:0]   in_use_q, in_use_d;
    logic                  err_q, err_d;

    logic       desc_pop, accept, alloc, rel_fire, rel_hit, rel_free;
    logic [2:0] occupancy;
    desc_t      push_dat;

    // Cells already committed downstream: queued descriptors plus the one in stage 1, minus the one leaving now.
    assign occupancy = {1'b0, desc_cnt_q} + {2'b00, s1_valid_q} - {2'b00, desc_pop};
    assign desc_valid = (desc_cnt_q != 2'd0);
    assign desc_pop   = desc_valid & desc_ready;
    assign cell_ready = ~fl_empty & (occupancy < 3'd2);
    assign accept     = cell_valid & cell_ready;
    assign alloc      = s1_valid_q;
    assign rel_fire   = rel_valid & ~fl_full;
    assign rel_hit    = bitmap_q[rel_addr];
    assign rel_free   = rel_fire & rel_hit;
    assign push_dat   = '{addr: fl_rd_data, dl: s1_dl_q};

    assign fl_rd_en        = accept;
    assign buf_we          = s1_valid_q;
    assign buf_waddr       = fl_rd_data;
    assign buf_wdata       = s1_data_q;
    assign fl_wr_en        = rel_free;
    assign fl_wr_data      = rel_addr;
    assign rel_ready       = ~fl_full;
    assign desc_addr       = head_q.addr;
    assign desc_deadline   = head_q.dl;
    assign in_use_cnt      = in_use_q;
    assign err_double_free = err_q;

    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = s1_data_q;
        s1_dl_d    = s1_dl_q;
        head_d     = head_q;
        tail_d     = tail_q;
        desc_cnt_d = desc_cnt_q + 2'(alloc) - 2'(desc_pop);
        bitmap_d   = bitmap_q;
        in_use_d   = in_use_q;
        err_d      = err_q | (rel_fire & ~rel_hit);

        if (accept) begin
            s1_data_d = cell_data;
            s1_dl_d   = cell_deadline;
        end

        if (alloc && desc_pop) begin
            if (desc_cnt_q == 2'd2) begin
                head_d = tail_q;
                tail_d = push_dat;
            end else begin
                head_d = push_dat;
            end
        end else if (alloc) begin
            if (desc_cnt_q == 2'd0) head_d = push_dat;
            else                    tail_d = push_dat;
        end else if (desc_pop) begin
            head_d = tail_q;
        end

        // Clear before set so a same-cycle alloc of the released address keeps the bit.
        if (rel_free) bitmap_d[rel_addr] = 1'b0;
        if (alloc)    bitmap_d[fl_rd_data] = 1'b1;

        if (alloc && !rel_free && in_use_q != POOL_CELLS) in_use_d = in_use_q + 1'b1;
        else if (!alloc && rel_free && in_use_q != '0)    in_use_d = in_use_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_dl_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            desc_cnt_q <= 2'd0;
            bitmap_q   <= '0;
            in_use_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_dl_q    <= s1_dl_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            desc_cnt_q <= desc_cnt_d;
            bitmap_q   <= bitmap_d;
            in_use_q   <= in_use_d;
            err_q      <= err_d;
        end
    end
endmodule
